ws2812_multi_registers: RTL and testbench
=========================================

// Module: ws2812_multi_registers
// PURPOSE
//  CPU-facing register file for WS2812 LED strips, generalised to CHANNELS strips.
//  Supports 3-byte (GRB/RGB) or 4-byte (RGBW) pixels and per-channel pixel counts.
//  Pixel index auto-advances and wraps at the channel count.
//  A hardware fill engine writes one colour to every pixel of a channel without CPU loops.
//  Sits between the I/O decode and a shared pixel RAM read by the strip drivers.
// PARAMETERS
//  CHANNELS         2    number of strips; channel c owns RAM bytes [c*MAX_PIXELS*BPP +: MAX_PIXELS*BPP]
//  MAX_PIXELS       64   pixels per channel; counts clamp to this value
//  BYTES_PER_PIXEL  3    3 or 4; written BPP below
//  PIX_AW           $clog2(CHANNELS*MAX_PIXELS*BYTES_PER_PIXEL)   pixel RAM address width
// PORTS
//  clk               in   1              system clock
//  reset_n           in   1              async active-low reset
//  addr              in   3              register select, 0..5; 6 and 7 are no-ops, read as 0
//  ws2812_io_req     in   1              one-cycle access strobe
//  ws2812_io_wr      in   1              1 = CPU write, 0 = CPU read (qualified by io_req)
//  ws2812_data_in    in   8              CPU write data
//  ws2812_data_out   out  8              CPU read data, registered, valid cycle after io_req
//  number_of_pixels  out  8*CHANNELS     per-channel counts; channel c at [c*8 +: 8]
//  fill_busy         out  1              fill engine active
//  pixel_we          out  1              one-cycle RAM write strobe
//  pixel_dbo         out  8              RAM write data
//  pixel_dbi         in   8              RAM read data for pixel_addr; valid 1 cycle after pixel_addr
//  pixel_addr        out  PIX_AW         RAM byte address
// BEHAVIOUR
//  Reset (async): all state and outputs return to their reset values.
//   - idx=0, phase=0, chan=0, all counts=MAX_PIXELS, fill colour=0.
//   - busy=0, pixel_we=0, pixel_dbo=0, data_out=0, pixel_addr=0.
//   - Reset during a fill aborts it; RAM contents are left partial.
//  pixel_addr = chan*MAX_PIXELS*BPP + idx*BPP + phase, registered.
//  pixel_we is high for exactly one cycle per RAM write.
//  Reg 0, write: idx = min(data, count-1), or 0 when count=0; phase=0.
//  Reg 0, read:  returns idx.
//  Reg 1, write: RAM[pixel_addr]=data, then phase+1.
//  Reg 1, read:  returns pixel_dbi, then phase+1.
//  Reg 1, phase wrap: when phase reaches BPP, phase=0 and idx+1.
//   - idx wraps to 0 when idx+1 >= count.
//   - count=0 holds idx at 0.
//  Reg 2, write: count[chan] = min(data, MAX_PIXELS).
//   - If the current idx >= the new count, idx=0 and phase=0.
//  Reg 2, read:  returns count[chan].
//  Reg 3, write: chan = data mod CHANNELS; idx=0, phase=0.
//  Reg 3, read:  returns chan.
//  Reg 4, write: stores fill colour byte fphase, then fphase=(fphase+1) mod BPP.
//  Reg 4, read:  returns 0 and sets fphase=0.
//  Reg 5, write: any value starts a fill on chan.
//  Reg 5, read:  returns {7'b0, busy}.
//  CPU reads complete in one cycle: data_out updates on the cycle after io_req.
//   - Bus rule: consecutive io_req pulses are at least 2 cycles apart.
//  Fill FSM states: IDLE, FILL, DONE.
//   - IDLE -> FILL on a reg 5 write; busy=1 from the next cycle.
//     Fill counter k runs 0..count*BPP-1.
//   - FILL: one RAM write per cycle, addr=chan base+k, data=colour[k mod BPP].
//     Leave FILL after k = count*BPP-1.
//   - DONE: idx=0, phase=0, busy=0 next cycle -> IDLE.
//   - count=0 at start: goes straight to DONE (busy high 1 cycle, no writes).
//   - Latency: busy is high for count*BPP+1 cycles.
//  While busy:
//   - All CPU writes are ignored.
//   - Reads of reg 1 return 0 and do not advance.
//   - Other reads behave normally.
//  io_req with io_wr changing mid-transaction is not supported.
// TESTING
//  1. Reset -> read reg2 = 64; write reg0=5, reg1 AA,BB,CC -> RAM[15..17]=AA,BB,CC; reg0 reads 6.
//  2. count=3, reg0=2, write 3 bytes -> idx wraps to 0; next byte lands at RAM[0].
//  3. BPP=4, chan=1, reg4 = 11,22,33,44, count=4, reg5 -> 16 writes at 256..271
//     (pattern 11,22,33,44 repeated); busy high 17 cycles.
//  4. During fill: write reg1=FF -> no RAM change; read reg5 = 01; after fill, read reg5 = 00.
//  5. count=0, reg5 -> busy 1 cycle, no pixel_we; writing reg2=200 reads back 64.
//  6. Assert reset_n mid-fill -> busy=0, pixel_we=0, counts=64 immediately.
//     The next fill starts cleanly.

Source files
------------

// File: rtl/ws2812_multi_registers.sv
// CPU register file for multi-channel WS2812 strips with a hardware colour-fill engine.
module ws2812_multi_registers #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned MAX_PIXELS      = 64,
    parameter int unsigned BYTES_PER_PIXEL = 3,
    parameter int unsigned PIX_AW          = $clog2(CHANNELS * MAX_PIXELS * BYTES_PER_PIXEL)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            addr,
    input  logic                  ws2812_io_req,
    input  logic                  ws2812_io_wr,
    input  logic [7:0]            ws2812_data_in,
    output logic [7:0]            ws2812_data_out,
    output logic [8*CHANNELS-1:0] number_of_pixels,
    output logic                  fill_busy,
    output logic                  pixel_we,
    output logic [7:0]            pixel_dbo,
    input  logic [7:0]            pixel_dbi,
    output logic [PIX_AW-1:0]     pixel_addr
);

    localparam int unsigned BPP      = BYTES_PER_PIXEL;
    localparam int unsigned CH_BYTES = MAX_PIXELS * BPP;
    localparam int unsigned CHW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned PHW      = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int unsigned KW       = $clog2(CH_BYTES + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [7:0]        idx_q, idx_d;
    logic [PHW-1:0]    phase_q, phase_d;
    logic [CHW-1:0]    chan_q, chan_d;
    logic [7:0]        count_q [CHANNELS];
    logic [7:0]        count_d [CHANNELS];
    logic [7:0]        colour_q [BPP];
    logic [7:0]        colour_d [BPP];
    logic [PHW-1:0]    fphase_q, fphase_d;
    logic [KW-1:0]     k_q, k_d;
    logic [PHW-1:0]    fk_q, fk_d;
    logic              busy_q, busy_d;
    logic              we_q, we_d;
    logic [7:0]        dbo_q, dbo_d;
    logic [7:0]        dout_q, dout_d;
    logic [PIX_AW-1:0] paddr_q, paddr_d;

    logic [7:0]     cur_count;
    logic [7:0]     new_count;
    logic [KW-1:0]  fill_end;
    logic           last_phase;
    logic           idx_wrap;
    logic [PHW-1:0] adv_phase;
    logic [7:0]     adv_idx;
    logic           wr_acc;
    logic           rd_acc;
    logic           hold_addr;

    // Next-state logic: CPU register access, pixel pointer advance and fill FSM
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        chan_d    = chan_q;
        count_d   = count_q;
        colour_d  = colour_q;
        fphase_d  = fphase_q;
        k_d       = k_q;
        fk_d      = fk_q;
        busy_d    = busy_q;
        we_d      = 1'b0;
        dbo_d     = dbo_q;
        dout_d    = dout_q;
        hold_addr = 1'b0;

        cur_count  = count_q[chan_q];
        new_count  = (ws2812_data_in > 8'(MAX_PIXELS)) ? 8'(MAX_PIXELS) : ws2812_data_in;
        fill_end   = KW'(cur_count) * KW'(BPP) - KW'(1);
        last_phase = (phase_q == PHW'(BPP - 1));
        idx_wrap   = ({1'b0, idx_q} + 9'd1) >= {1'b0, cur_count};
        adv_phase  = last_phase ? '0 : phase_q + PHW'(1);
        adv_idx    = last_phase ? (idx_wrap ? 8'd0 : idx_q + 8'd1) : idx_q;
        wr_acc     = ws2812_io_req && ws2812_io_wr && !busy_q;
        rd_acc     = ws2812_io_req && !ws2812_io_wr;

        // CPU writes are dropped while the fill engine owns the RAM port
        if (wr_acc) begin
            case (addr)
                3'd0: begin
                    if (cur_count == 8'd0)
                        idx_d = 8'd0;
                    else if (ws2812_data_in >= cur_count)
                        idx_d = cur_count - 8'd1;
                    else
                        idx_d = ws2812_data_in;
                    phase_d = '0;
                end
                3'd1: begin
                    we_d      = 1'b1;
                    dbo_d     = ws2812_data_in;
                    phase_d   = adv_phase;
                    idx_d     = adv_idx;
                    hold_addr = 1'b1;
                end
                3'd2: begin
                    count_d[chan_q] = new_count;
                    if (idx_q >= new_count) begin
                        idx_d   = 8'd0;
                        phase_d = '0;
                    end
                end
                3'd3: begin
                    chan_d  = CHW'(32'(ws2812_data_in) % CHANNELS);
                    idx_d   = 8'd0;
                    phase_d = '0;
                end
                3'd4: begin
                    colour_d[fphase_q] = ws2812_data_in;
                    fphase_d = (fphase_q == PHW'(BPP - 1)) ? '0 : fphase_q + PHW'(1);
                end
                default: ;
            endcase
        end

        // CPU reads; pixel data reads are blanked and frozen during a fill
        if (rd_acc) begin
            case (addr)
                3'd0: dout_d = idx_q;
                3'd1: begin
                    if (busy_q) begin
                        dout_d = 8'd0;
                    end else begin
                        dout_d  = pixel_dbi;
                        phase_d = adv_phase;
                        idx_d   = adv_idx;
                    end
                end
                3'd2: dout_d = cur_count;
                3'd3: dout_d = 8'(chan_q);
                3'd4: begin
                    dout_d   = 8'd0;
                    fphase_d = '0;
                end
                3'd5:    dout_d = {7'b0, busy_q};
                default: dout_d = 8'd0;
            endcase
        end

        // Fill engine: one RAM byte per cycle across the channel's active region
        case (state_q)
            S_IDLE: begin
                if (wr_acc && addr == 3'd5) begin
                    busy_d  = 1'b1;
                    k_d     = '0;
                    fk_d    = '0;
                    state_d = (cur_count == 8'd0) ? S_DONE : S_FILL;
                end
            end
            S_FILL: begin
                we_d  = 1'b1;
                dbo_d = colour_q[fk_q];
                k_d   = k_q + KW'(1);
                fk_d  = (fk_q == PHW'(BPP - 1)) ? '0 : fk_q + PHW'(1);
                if (k_q == fill_end)
                    state_d = S_DONE;
            end
            S_DONE: begin
                idx_d   = 8'd0;
                phase_d = '0;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Address tracks the pointer, except it holds for the write strobe cycle
        if (state_q == S_FILL)
            paddr_d = PIX_AW'(chan_q) * PIX_AW'(CH_BYTES) + PIX_AW'(k_q);
        else if (hold_addr)
            paddr_d = PIX_AW'(chan_q) * PIX_AW'(CH_BYTES) + PIX_AW'(idx_q) * PIX_AW'(BPP)
                    + PIX_AW'(phase_q);
        else
            paddr_d = PIX_AW'(chan_d) * PIX_AW'(CH_BYTES) + PIX_AW'(idx_d) * PIX_AW'(BPP)
                    + PIX_AW'(phase_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            idx_q    <= 8'd0;
            phase_q  <= '0;
            chan_q   <= '0;
            fphase_q <= '0;
            k_q      <= '0;
            fk_q     <= '0;
            busy_q   <= 1'b0;
            we_q     <= 1'b0;
            dbo_q    <= 8'd0;
            dout_q   <= 8'd0;
            paddr_q  <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) count_q[c] <= 8'(MAX_PIXELS);
            for (int b = 0; b < int'(BPP); b++) colour_q[b] <= 8'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            chan_q   <= chan_d;
            fphase_q <= fphase_d;
            k_q      <= k_d;
            fk_q     <= fk_d;
            busy_q   <= busy_d;
            we_q     <= we_d;
            dbo_q    <= dbo_d;
            dout_q   <= dout_d;
            paddr_q  <= paddr_d;
            count_q  <= count_d;
            colour_q <= colour_d;
        end
    end

    // Flatten per-channel counts onto the output bus
    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_counts
        assign number_of_pixels[c*8 +: 8] = count_q[c];
    end

    assign ws2812_data_out = dout_q;
    assign fill_busy       = busy_q;
    assign pixel_we        = we_q;
    assign pixel_dbo       = dbo_q;
    assign pixel_addr      = paddr_q;

endmodule

// File: tb/tb_ws2812_multi_registers.sv
// Bench: a 3-byte and a 4-byte instance share the bus; RAM writes and reads are scoreboarded.
module tb_ws2812_multi_registers;

    localparam int unsigned AW = 9;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] addr;
    logic       io_wr;
    logic [7:0] din;
    logic       req3, req4;

    logic [7:0]    dout3, dout4, dbo3, dbo4, dbi3, dbi4;
    logic [15:0]   npix3, npix4;
    logic          busy3, busy4, we3, we4;
    logic [AW-1:0] paddr3, paddr4;

    logic [7:0] mem3 [512];
    logic [7:0] mem4 [512];

    int total = 0;
    int bad   = 0;
    int bcnt3 = 0;
    int bcnt4 = 0;

    logic [31:0] wq3 [$];
    logic [31:0] wq4 [$];
    logic [7:0]  rdq [$];

    always #5 clk = ~clk;

    ws2812_multi_registers #(.CHANNELS(2), .MAX_PIXELS(64), .BYTES_PER_PIXEL(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .ws2812_io_req(req3), .ws2812_io_wr(io_wr),
        .ws2812_data_in(din), .ws2812_data_out(dout3), .number_of_pixels(npix3),
        .fill_busy(busy3), .pixel_we(we3), .pixel_dbo(dbo3), .pixel_dbi(dbi3), .pixel_addr(paddr3));

    ws2812_multi_registers #(.CHANNELS(2), .MAX_PIXELS(64), .BYTES_PER_PIXEL(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .ws2812_io_req(req4), .ws2812_io_wr(io_wr),
        .ws2812_data_in(din), .ws2812_data_out(dout4), .number_of_pixels(npix4),
        .fill_busy(busy4), .pixel_we(we4), .pixel_dbo(dbo4), .pixel_dbi(dbi4), .pixel_addr(paddr4));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Synchronous pixel RAMs, one-cycle read latency
    always @(posedge clk) begin
        if (we3) mem3[paddr3] <= dbo3;
        if (we4) mem4[paddr4] <= dbo4;
        dbi3 <= mem3[paddr3];
        dbi4 <= mem4[paddr4];
    end

    // RAM write scoreboard and busy-cycle counters
    always @(negedge clk) begin : mon
        logic [31:0] e;
        if (reset_n && we3) begin
            e = (wq3.size() > 0) ? wq3.pop_front() : 32'hFFFF_FFFF;
            check("ram_wr3", 32'({paddr3, dbo3}), e);
        end
        if (reset_n && we4) begin
            e = (wq4.size() > 0) ? wq4.pop_front() : 32'hFFFF_FFFF;
            check("ram_wr4", 32'({paddr4, dbo4}), e);
        end
        if (busy3) bcnt3 <= bcnt3 + 1;
        if (busy4) bcnt4 <= bcnt4 + 1;
    end

    function automatic logic [31:0] wexp(input int a, input logic [7:0] d);
        return 32'({9'(a), d});
    endfunction

    task automatic cpu(input int sel, input bit wr, input logic [2:0] a, input logic [7:0] d,
                       input logic [7:0] exp, input string tag);
        @(posedge clk); #1;
        addr = a; io_wr = wr; din = d;
        if (sel == 0) req3 = 1'b1; else req4 = 1'b1;
        if (!wr) rdq.push_back(exp);
        @(posedge clk); #1;
        req3 = 1'b0; req4 = 1'b0;
        if (!wr) check(tag, 32'((sel == 0) ? dout3 : dout4), 32'(rdq.pop_front()));
    endtask

    task automatic wr(input int sel, input logic [2:0] a, input logic [7:0] d);
        cpu(sel, 1'b1, a, d, 8'd0, "");
    endtask

    task automatic rd(input int sel, input logic [2:0] a, input logic [7:0] exp, input string tag);
        cpu(sel, 1'b0, a, 8'd0, exp, tag);
    endtask

    task automatic wait_idle(input int sel, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            done = (sel == 0) ? !busy3 : !busy4;
        end
        if (!done) check(tag, 32'd1, 32'd0);
    endtask

    initial begin #2_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        int b0;
        logic [7:0] pat [4];
        reset_n = 1'b0; addr = 3'd0; io_wr = 1'b0; din = 8'd0; req3 = 1'b0; req4 = 1'b0;
        for (int i = 0; i < 512; i++) begin mem3[i] = 8'd0; mem4[i] = 8'd0; end
        pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 32'(dout3), 32'd0);
        check("rst_busy", 32'(busy3), 32'd0);
        check("rst_we", 32'({we3, we4}), 32'd0);
        check("rst_addr", 32'(paddr3), 32'd0);
        check("rst_npix", 32'({npix3, npix4}), 32'h4040_4040);
        reset_n = 1'b1;

        // 3-byte pixels: indexed writes and readback
        rd(0, 3'd2, 8'd64, "rd_count_rst");
        wr(0, 3'd0, 8'd5);
        wq3.push_back(wexp(15, 8'hAA)); wq3.push_back(wexp(16, 8'hBB)); wq3.push_back(wexp(17, 8'hCC));
        wr(0, 3'd1, 8'hAA); wr(0, 3'd1, 8'hBB); wr(0, 3'd1, 8'hCC);
        rd(0, 3'd0, 8'd6, "idx_after_px");
        wr(0, 3'd0, 8'd5);
        rd(0, 3'd1, 8'hAA, "rd_px0");
        rd(0, 3'd1, 8'hBB, "rd_px1");
        rd(0, 3'd6, 8'd0, "rd_reg6");

        // Index wrap at a short count
        wr(0, 3'd2, 8'd3);
        rd(0, 3'd2, 8'd3, "rd_count3");
        wr(0, 3'd0, 8'd2);
        wq3.push_back(wexp(6, 8'h11)); wq3.push_back(wexp(7, 8'h22)); wq3.push_back(wexp(8, 8'h33));
        wr(0, 3'd1, 8'h11); wr(0, 3'd1, 8'h22); wr(0, 3'd1, 8'h33);
        rd(0, 3'd0, 8'd0, "idx_wrap");
        wq3.push_back(wexp(0, 8'h44));
        wr(0, 3'd1, 8'h44);
        wr(0, 3'd0, 8'd200);
        rd(0, 3'd0, 8'd2, "idx_clamp");

        // 4-byte pixels: fill channel 1, with CPU traffic during the fill
        wr(1, 3'd3, 8'd1);
        rd(1, 3'd3, 8'd1, "rd_chan");
        for (int i = 0; i < 4; i++) wr(1, 3'd4, pat[i]);
        rd(1, 3'd4, 8'd0, "rd_reg4");
        wr(1, 3'd2, 8'd4);
        for (int i = 0; i < 16; i++) wq4.push_back(wexp(256 + i, pat[i % 4]));
        b0 = bcnt4;
        wr(1, 3'd5, 8'd0);
        wr(1, 3'd1, 8'hFF);
        rd(1, 3'd5, 8'd1, "busy_rd");
        rd(1, 3'd1, 8'd0, "px_rd_busy");
        rd(1, 3'd3, 8'd1, "chan_rd_busy");
        wait_idle(1, "fill4_timeout");
        check("fill4_busy_cycles", 32'(bcnt4 - b0), 32'd17);
        check("fill4_all_written", 32'(wq4.size()), 32'd0);
        rd(1, 3'd5, 8'd0, "idle_rd");
        rd(1, 3'd0, 8'd0, "idx_after_fill");
        check("npix4", 32'(npix4), 32'h0440);

        // Zero-length fill and count clamp
        wr(0, 3'd2, 8'd0);
        rd(0, 3'd2, 8'd0, "rd_count0");
        b0 = bcnt3;
        wr(0, 3'd5, 8'd0);
        wait_idle(0, "fill0_timeout");
        check("fill0_busy_cycles", 32'(bcnt3 - b0), 32'd1);
        wr(0, 3'd2, 8'd200);
        rd(0, 3'd2, 8'd64, "rd_count_clamp");

        // Reset in the middle of a fill, then a clean fill
        for (int i = 0; i < 16; i++) wq4.push_back(wexp(256 + i, pat[i % 4]));
        wr(1, 3'd5, 8'd0);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_we", 32'(we4), 32'd0);
        check("abort_npix", 32'({npix3, npix4}), 32'h4040_4040);
        check("abort_addr", 32'(paddr4), 32'd0);
        wq4.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) wr(1, 3'd4, 8'(i + 1));
        wr(1, 3'd2, 8'd2);
        for (int i = 0; i < 8; i++) wq4.push_back(wexp(i, 8'(i % 4 + 1)));
        b0 = bcnt4;
        wr(1, 3'd5, 8'd0);
        wait_idle(1, "refill_timeout");
        check("refill_busy_cycles", 32'(bcnt4 - b0), 32'd9);
        check("refill_all_written", 32'(wq4.size()), 32'd0);
        check("px3_leftover", 32'(wq3.size()), 32'd0);
        check("mem3_17", 32'(mem3[17]), 32'hCC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
